// File: rtl/alu_exec_unit_if.sv
// Request/write-back bundle between the register file side and the ALU execute stage.
// The master issues ops and observes write-back; the slave is the execute unit.
interface alu_exec_if #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 2
);
  logic             start;
  logic [2:0]       opcode;
  logic [SEL_W-1:0] dest_sel;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic             wb_en;
  logic [SEL_W-1:0] wb_sel;
  logic [WIDTH-1:0] wb_data;
  logic             flag_z;
  logic             flag_c;

  modport master (
    output start, opcode, dest_sel, op_a, op_b,
    input  busy, done, wb_en, wb_sel, wb_data, flag_z, flag_c
  );

  modport slave (
    input  start, opcode, dest_sel, op_a, op_b,
    output busy, done, wb_en, wb_sel, wb_data, flag_z, flag_c
  );
endinterface

// File: rtl/alu_exec_unit.sv
// ALU execute stage: latches operands on start, runs a 2-cycle single-op path or an
// iterative shift-add multiply, then issues a one-cycle register-file write-back.
module alu_exec_unit #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 2
) (
  input  logic       clk,
  input  logic       reset,
  alu_exec_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_WB} state_t;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0, OP_SUB  = 3'd1, OP_AND  = 3'd2, OP_OR  = 3'd3,
    OP_XOR  = 3'd4, OP_SHL1 = 3'd5, OP_SHR1 = 3'd6, OP_MUL = 3'd7
  } op_t;

  state_t             state, state_nx;
  op_t                op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [SEL_W-1:0]   sel_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic [2*WIDTH-1:0] mul_sum;
  logic               mul_last;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  assign mul_last = (cnt_q == CNT_W'(WIDTH - 1));

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (bus.start) state_nx = (op_t'(bus.opcode) == OP_MUL) ? S_MUL : S_EXEC;
      S_EXEC: state_nx = S_WB;
      S_MUL:  if (mul_last) state_nx = S_WB;
      S_WB:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    case (op_q)
      OP_ADD:  {alu_c, alu_res} = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB:  {alu_c, alu_res} = {1'b0, a_q} - {1'b0, b_q};
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_SHL1: begin alu_res = a_q << 1; alu_c = a_q[WIDTH-1]; end
      OP_SHR1: begin alu_res = a_q >> 1; alu_c = a_q[0];       end
      default: begin alu_res = '0;       alu_c = 1'b0;         end
    endcase
  end

  // Partial product for the current multiplier bit; used both to advance and to finish.
  assign mul_sum = acc_q + (b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0);

  // NOTE: the multiply counter/accumulator are reset too, so an abandoned op leaves no residue.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      bus.wb_sel  <= '0;
      bus.wb_data <= '0;
      bus.flag_z  <= 1'b0;
      bus.flag_c  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt_q <= '0;
          acc_q <= '0;
          if (bus.start) begin
            op_q  <= op_t'(bus.opcode);
            a_q   <= bus.op_a;
            b_q   <= bus.op_b;
            sel_q <= bus.dest_sel;
          end
        end
        S_EXEC: begin
          bus.wb_sel  <= sel_q;
          bus.wb_data <= alu_res;
          bus.flag_c  <= alu_c;
          bus.flag_z  <= (alu_res == '0);
        end
        S_MUL: begin
          acc_q <= mul_sum;
          cnt_q <= cnt_q + 1'b1;
          if (mul_last) begin
            bus.wb_sel  <= sel_q;
            bus.wb_data <= mul_sum[WIDTH-1:0];
            bus.flag_c  <= |mul_sum[2*WIDTH-1:WIDTH];
            bus.flag_z  <= (mul_sum[WIDTH-1:0] == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = (state != S_IDLE);
  assign bus.wb_en = (state == S_WB);
  assign bus.done  = (state == S_WB);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios plus randomized ops
// compared against an arithmetic reference model.
module tb_alu_exec_unit;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  alu_exec_if #(.WIDTH(8), .SEL_W(2)) bus ();

  alu_exec_unit #(.WIDTH(8), .SEL_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {carry, zero, data}, computed from the op definitions with integer arithmetic.
  function automatic logic [9:0] ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int  r;
    logic c;
    c = 1'b0;
    case (op)
      3'd0: begin r = int'(a) + int'(b); c = (r > 255); end
      3'd1: begin r = int'(a) - int'(b) + 256; c = (a < b); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin r = int'(a) * 2; c = (a >= 8'd128); end
      3'd6: begin r = int'(a) / 2; c = (a % 2 == 1); end
      default: begin r = int'(a) * int'(b); c = (r > 255); end
    endcase
    r = r % 256;
    return {c, (r == 0), 8'(r)};
  endfunction

  // Issues one op, scrambles the inputs after acceptance, optionally pulses start
  // in cycle poke_cyc and in the WB cycle, and checks the whole write-back.
  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] sel, input int poke_cyc, input bit wb_poke);
    logic [9:0] exp;
    int lat;
    exp = ref_alu(op, a, b);
    bus.opcode = op; bus.op_a = a; bus.op_b = b; bus.dest_sel = sel; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.opcode = 3'd0; bus.op_a = 8'($urandom); bus.op_b = 8'($urandom); bus.dest_sel = 2'($urandom);
    lat = 1;
    while (!bus.wb_en && lat < 20) begin
      check("busy_during_op", 16'(bus.busy), 16'd1);
      bus.start = (lat == poke_cyc);
      tick();
      bus.start = 1'b0;
      lat++;
    end
    check("latency", 16'(lat), (op == 3'd7) ? 16'd9 : 16'd2);
    check("wb_en", 16'(bus.wb_en), 16'd1);
    check("done", 16'(bus.done), 16'd1);
    check("busy_wb", 16'(bus.busy), 16'd1);
    check("wb_sel", 16'(bus.wb_sel), 16'(sel));
    check("wb_data", 16'(bus.wb_data), 16'(exp[7:0]));
    check("flag_z", 16'(bus.flag_z), 16'(exp[8]));
    check("flag_c", 16'(bus.flag_c), 16'(exp[9]));
    bus.start = wb_poke;
    tick();
    bus.start = 1'b0;
    check("wb_en_after", 16'(bus.wb_en), 16'd0);
    check("busy_after", 16'(bus.busy), 16'd0);
    tick();
    check("busy_idle", 16'(bus.busy), 16'd0);
    check("wb_en_idle", 16'(bus.wb_en), 16'd0);
    check("data_hold", 16'(bus.wb_data), 16'(exp[7:0]));
    check("flags_hold", 16'({bus.flag_c, bus.flag_z}), 16'({exp[9], exp[8]}));
  endtask

  initial begin
    logic [9:0] e_add, e_xor, e_shl;
    logic [2:0] rop;
    int pk;
    bit busy_exp [9];
    bit wb_exp   [9];

    reset = 1'b1;
    bus.start = 1'b0; bus.opcode = '0; bus.dest_sel = '0; bus.op_a = '0; bus.op_b = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_busy", 16'(bus.busy), 16'd0);
    check("rst_wb_en", 16'(bus.wb_en), 16'd0);
    check("rst_done", 16'(bus.done), 16'd0);
    check("rst_outs", 16'({bus.wb_sel, bus.wb_data, bus.flag_z, bus.flag_c}), 16'd0);

    // Directed scenarios
    run_op(3'd0, 8'hF0, 8'h20, 2'd2, 0, 1'b0);
    check("add_f0_20", 16'(bus.wb_data), 16'h10);
    run_op(3'd1, 8'h05, 8'h05, 2'd1, 0, 1'b0);
    run_op(3'd1, 8'h03, 8'h05, 2'd3, 0, 1'b0);
    check("sub_borrow", 16'({bus.flag_c, bus.wb_data}), 16'h1FE);
    run_op(3'd7, 8'h0D, 8'h0B, 2'd0, 0, 1'b0);
    check("mul_0d_0b", 16'(bus.wb_data), 16'h8F);
    run_op(3'd7, 8'h10, 8'h10, 2'd1, 0, 1'b0);
    check("mul_10_10", 16'({bus.flag_c, bus.flag_z, bus.wb_data}), 16'h300);
    run_op(3'd7, 8'hFF, 8'hFF, 2'd3, 4, 1'b1);
    run_op(3'd0, 8'h7F, 8'h01, 2'd2, 1, 1'b1);

    // Reset during a multiply abandons it
    bus.opcode = 3'd7; bus.op_a = 8'h0D; bus.op_b = 8'h0B; bus.dest_sel = 2'd3; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    check("mul_busy_c4", 16'(bus.busy), 16'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_busy", 16'(bus.busy), 16'd0);
    check("mrst_outs", 16'({bus.wb_en, bus.done, bus.wb_sel, bus.wb_data, bus.flag_z, bus.flag_c}), 16'd0);
    for (int i = 0; i < 12; i++) begin
      check("mrst_no_wb", 16'(bus.wb_en), 16'd0);
      tick();
    end
    run_op(3'd0, 8'h01, 8'h01, 2'd1, 0, 1'b0);
    check("add_01_01", 16'(bus.wb_data), 16'h02);

    // start held high: ADD, XOR, SHL1 accepted at cycles 0, 3, 6
    e_add = ref_alu(3'd0, 8'h81, 8'h7F);
    e_xor = ref_alu(3'd4, 8'h81, 8'h7F);
    e_shl = ref_alu(3'd5, 8'h81, 8'h00);
    busy_exp = '{0, 1, 1, 0, 1, 1, 0, 1, 1};
    wb_exp   = '{0, 0, 1, 0, 0, 1, 0, 0, 1};
    bus.opcode = 3'd0; bus.op_a = 8'h81; bus.op_b = 8'h7F; bus.dest_sel = 2'd1; bus.start = 1'b1;
    check("hold_busy_c0", 16'(bus.busy), 16'd0);
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) bus.opcode = 3'd4;
      if (c == 4) begin bus.opcode = 3'd5; bus.op_b = 8'h00; end
      if (c == 7) begin bus.op_a = 8'h00; bus.start = 1'b0; end
      check("hold_busy", 16'(bus.busy), 16'(busy_exp[c]));
      check("hold_wb_en", 16'(bus.wb_en), 16'(wb_exp[c]));
      if (c == 2) check("hold_add", 16'({bus.flag_c, bus.flag_z, bus.wb_data}), 16'({e_add[9], e_add[8], e_add[7:0]}));
      if (c == 5) check("hold_xor", 16'({bus.flag_c, bus.flag_z, bus.wb_data}), 16'({e_xor[9], e_xor[8], e_xor[7:0]}));
      if (c == 8) check("hold_shl", 16'({bus.flag_c, bus.flag_z, bus.wb_data}), 16'({e_shl[9], e_shl[8], e_shl[7:0]}));
    end
    check("shl_81", 16'({bus.flag_c, bus.wb_data}), 16'h102);
    tick();
    check("hold_idle", 16'(bus.busy), 16'd0);

    // Randomized ops against the reference model
    for (int n = 0; n < 60; n++) begin
      rop = 3'($urandom_range(0, 7));
      pk  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, (rop == 3'd7) ? 8 : 1) : 0;
      run_op(rop, 8'($urandom), 8'($urandom), 2'($urandom), pk, 1'($urandom));
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
